// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with standard or first-word-fall-through read and programmable thresholds
module sync_fifo_param #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT = 0,
  parameter int PROG_FULL = 12,
  parameter int PROG_EMPTY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  valid,
  output logic                  underflow,
  output logic                  prog_full,
  output logic                  prog_empty,
  output logic [ADDR_WIDTH:0]   data_count
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PF = PROG_FULL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] PE = PROG_EMPTY[ADDR_WIDTH:0];
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0] mem_cnt, mem_cnt_n, data_count_n;
  logic mem_has, wr_acc, mem_rd, valid_n, underflow_n;
  always_comb begin
    mem_has = mem_cnt != '0;
    wr_acc = wr_en && !full;
    mem_rd = (FWFT != 0) ? (!valid || rd_en) && mem_has : rd_en && mem_has;
    valid_n = (FWFT != 0) ? mem_rd || (valid && !rd_en) : mem_rd;
    underflow_n = (FWFT != 0) ? rd_en && !valid : rd_en && !mem_has;
    mem_cnt_n = mem_cnt + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, mem_rd};
    data_count_n = (FWFT != 0) ? mem_cnt_n + {{ADDR_WIDTH{1'b0}}, valid_n} : mem_cnt_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem_cnt <= '0;
      dout <= '0;
      valid <= 1'b0;
      wr_ack <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      full <= 1'b0;
      empty <= 1'b1;
      prog_full <= 1'b0;
      prog_empty <= 1'b1;
      data_count <= '0;
    end else begin
      if (wr_acc) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (mem_rd) begin
        dout <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      mem_cnt <= mem_cnt_n;
      valid <= valid_n;
      wr_ack <= wr_acc;
      overflow <= wr_en && full;
      underflow <= underflow_n;
      full <= mem_cnt_n == DEPTH;
      empty <= (FWFT != 0) ? !valid_n : mem_cnt_n == '0;
      prog_full <= data_count_n >= PF;
      prog_empty <= data_count_n <= PE;
      data_count <= data_count_n;
    end
  end
endmodule
